// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: serialises one NEC IR frame (address, ~address, command,
// ~command, LSB first) onto a 38 kHz carrier for the IRDA TX LED.
// Optional build macro NEC_TX_REPEAT_EN: holding start across done sends NEC
// repeat codes every REPEAT_UNITS units instead of retransmitting full frames.
module nec_ir_transmitter #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 439,
    parameter int REPEAT_UNITS = 192
) (
    input  logic       master_clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] address,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       ir_envelope,
    output logic       ir_txd
);

    localparam int UNIT_W = $clog2(UNIT_CYCLES);
    localparam int CAR_W  = $clog2(CARRIER_DIV);

    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] UNIT_ONE  = UNIT_W'(1);
    localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'(CARRIER_DIV - 1);
    localparam logic [CAR_W-1:0]  CAR_ONE   = CAR_W'(1);
    localparam logic [CAR_W-1:0]  CAR_HIGH  = CAR_W'(CARRIER_HIGH);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP_MARK  = 3'd5;
`ifdef NEC_TX_REPEAT_EN
    localparam logic [2:0] S_REP_WAIT   = 3'd6;
    localparam logic [2:0] S_REP_SPACE  = 3'd7;

    localparam int REP_W = $clog2(REPEAT_UNITS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_UNITS - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
`endif

    // Current state and counters
    logic [2:0]        r_state;
    logic [UNIT_W-1:0] r_unit_cnt;   // cycle within the current unit
    logic [3:0]        r_unit_idx;   // unit within the current state
    logic [4:0]        r_bit_cnt;
    logic [31:0]       r_shift;
    logic [CAR_W-1:0]  r_carrier;
    logic              r_busy;
    logic              r_done;
    logic              r_env;
    logic              r_txd;
`ifdef NEC_TX_REPEAT_EN
    logic [REP_W-1:0]  r_rep_units;  // units since last frame/repeat start
    logic              r_rep;        // current burst is a repeat code
`endif

    // Next-state values
    logic [2:0]        w_nxt_state;
    logic [UNIT_W-1:0] w_nxt_unit_cnt;
    logic [3:0]        w_nxt_unit_idx;
    logic [4:0]        w_nxt_bit_cnt;
    logic [31:0]       w_nxt_shift;
    logic [CAR_W-1:0]  w_nxt_carrier;
    logic              w_nxt_done;
    logic              w_unit_end;
    logic              w_state_end;
    logic              w_accept;
    logic [3:0]        w_last_idx;
`ifdef NEC_TX_REPEAT_EN
    logic [REP_W-1:0]  w_nxt_rep_units;
    logic              w_nxt_rep;
`endif

    function automatic logic f_is_mark(input logic [2:0] s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

    // Next-state, counter and shift-register logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_nxt_state    = r_state;
        w_unit_end     = (r_unit_cnt == UNIT_LAST);
        w_nxt_unit_cnt = w_unit_end ? '0 : r_unit_cnt + UNIT_ONE;
        w_nxt_bit_cnt  = r_bit_cnt;
        w_nxt_shift    = r_shift;
        w_nxt_carrier  = (r_carrier == CAR_LAST) ? '0 : r_carrier + CAR_ONE;
        w_nxt_done     = 1'b0;
`ifdef NEC_TX_REPEAT_EN
        w_nxt_rep_units = (w_unit_end && r_rep_units != REP_LAST) ?
                          r_rep_units + REP_ONE : r_rep_units;
        w_nxt_rep       = r_rep;
        w_accept        = (r_state == S_IDLE) && start && !r_done;
`else
        w_accept        = (r_state == S_IDLE) && start;
`endif

        // Length of the current state in units, minus one
        case (r_state)
            S_LEAD_MARK:  w_last_idx = 4'd15;
            S_LEAD_SPACE: w_last_idx = 4'd7;
            S_BIT_SPACE:  w_last_idx = r_shift[0] ? 4'd2 : 4'd0;
`ifdef NEC_TX_REPEAT_EN
            S_REP_SPACE:  w_last_idx = 4'd3;
`endif
            default:      w_last_idx = 4'd0;
        endcase
        w_state_end    = w_unit_end && (r_unit_idx == w_last_idx);
        w_nxt_unit_idx = w_state_end ? '0 :
                         (w_unit_end ? r_unit_idx + 4'd1 : r_unit_idx);

        case (r_state)
            S_IDLE: begin
                w_nxt_unit_cnt = '0;
                w_nxt_unit_idx = '0;
                w_nxt_carrier  = '0;
`ifdef NEC_TX_REPEAT_EN
                if (r_done && start) begin
                    // Keep the unit clock running so the repeat period stays
                    // aligned to the previous frame start.
                    w_nxt_state    = S_REP_WAIT;
                    w_nxt_unit_cnt = r_unit_cnt + UNIT_ONE;
                end else begin
                    w_nxt_rep_units = '0;
                    w_nxt_rep       = 1'b0;
                end
`endif
            end
            S_LEAD_MARK: begin
                if (w_state_end) begin
`ifdef NEC_TX_REPEAT_EN
                    w_nxt_state = r_rep ? S_REP_SPACE : S_LEAD_SPACE;
`else
                    w_nxt_state = S_LEAD_SPACE;
`endif
                end
            end
            S_LEAD_SPACE: begin
                if (w_state_end) begin
                    w_nxt_state   = S_BIT_MARK;
                    w_nxt_carrier = '0;
                end
            end
            S_BIT_MARK: begin
                if (w_state_end) w_nxt_state = S_BIT_SPACE;
            end
            S_BIT_SPACE: begin
                if (w_state_end) begin
                    w_nxt_shift   = r_shift >> 1;
                    w_nxt_bit_cnt = r_bit_cnt + 5'd1;
                    w_nxt_state   = (r_bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                    w_nxt_carrier = '0;
                end
            end
            S_STOP_MARK: begin
                if (w_state_end) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_done  = 1'b1;
                end
            end
`ifdef NEC_TX_REPEAT_EN
            S_REP_WAIT: begin
                w_nxt_unit_idx = '0;
                if (w_unit_end && r_rep_units == REP_LAST) begin
                    w_nxt_state     = S_LEAD_MARK;
                    w_nxt_carrier   = '0;
                    w_nxt_rep       = 1'b1;
                    w_nxt_rep_units = '0;
                end
            end
            S_REP_SPACE: begin
                if (w_state_end) begin
                    w_nxt_state   = S_STOP_MARK;
                    w_nxt_carrier = '0;
                end
            end
`endif
            default: w_nxt_state = S_IDLE;
        endcase

        if (w_accept) begin
            w_nxt_state   = S_LEAD_MARK;
            w_nxt_shift   = {~command, command, ~address, address};
            w_nxt_bit_cnt = '0;
`ifdef NEC_TX_REPEAT_EN
            w_nxt_rep_units = '0;
            w_nxt_rep       = 1'b0;
`endif
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge master_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_unit_cnt  <= '0;
            r_unit_idx  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_carrier   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_env       <= 1'b0;
            r_txd       <= 1'b0;
`ifdef NEC_TX_REPEAT_EN
            r_rep_units <= '0;
            r_rep       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_nxt_state;
            r_unit_cnt  <= w_nxt_unit_cnt;
            r_unit_idx  <= w_nxt_unit_idx;
            r_bit_cnt   <= w_nxt_bit_cnt;
            r_shift     <= w_nxt_shift;
            r_carrier   <= w_nxt_carrier;
            r_busy      <= (w_nxt_state != S_IDLE);
            r_done      <= w_nxt_done;
            r_env       <= f_is_mark(w_nxt_state);
            r_txd       <= f_is_mark(w_nxt_state) && (w_nxt_carrier < CAR_HIGH);
`ifdef NEC_TX_REPEAT_EN
            r_rep_units <= w_nxt_rep_units;
            r_rep       <= w_nxt_rep;
`endif
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign ir_envelope = r_env;
    assign ir_txd      = r_txd;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Self-checking bench for nec_ir_transmitter. Expected waveforms are built
// from the frame rules (mark/space unit lengths, carrier phase per mark).
module tb_nec_ir_transmitter;

    localparam int UNIT = 10;
    localparam int DIV  = 4;
    localparam int HIGH = 1;
    localparam int REP  = 192;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] address;
    logic [7:0] command;
    logic       busy;
    logic       done;
    logic       ir_envelope;
    logic       ir_txd;

    always #5 clk = ~clk;

    nec_ir_transmitter #(
        .UNIT_CYCLES (UNIT),
        .CARRIER_DIV (DIV),
        .CARRIER_HIGH(HIGH),
        .REPEAT_UNITS(REP)
    ) dut (
        .master_clk (clk),
        .resetn     (resetn),
        .start      (start),
        .address    (address),
        .command    (command),
        .busy       (busy),
        .done       (done),
        .ir_envelope(ir_envelope),
        .ir_txd     (ir_txd)
    );

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    // Expected per-cycle {busy, done, envelope, txd}
    logic [3:0] exp_q[$];
    bit         env_rec[$];

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  cmd;
        int          poke_k;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: waveform from NEC unit lengths
    function automatic void push_mark(input int units);
        for (int c = 0; c < units * UNIT; c++)
            exp_q.push_back({1'b1, 1'b0, 1'b1, ((c % DIV) < HIGH)});
    endfunction

    function automatic void push_busy_low(input int cycles);
        for (int c = 0; c < cycles; c++) exp_q.push_back(4'b1000);
    endfunction

    function automatic void push_idle(input int cycles);
        for (int c = 0; c < cycles; c++) exp_q.push_back(4'b0000);
    endfunction

    function automatic void push_frame(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] word;
        word = {~c, c, ~a, a};
        push_mark(16);
        push_busy_low(8 * UNIT);
        for (int i = 0; i < 32; i++) begin
            push_mark(1);
            push_busy_low((word[i] ? 3 : 1) * UNIT);
        end
        push_mark(1);
        exp_q.push_back(4'b0100);
    endfunction

    function automatic void push_repeat();
        push_mark(16);
        push_busy_low(4 * UNIT);
        push_mark(1);
        exp_q.push_back(4'b0100);
    endfunction

    // Recover the 32-bit payload from recorded envelope space widths
    function automatic logic [31:0] decode();
        int i = 0;
        int s;
        logic [31:0] w = '0;
        while (i < env_rec.size() && env_rec[i]) i++;
        while (i < env_rec.size() && !env_rec[i]) i++;
        for (int b = 0; b < 32; b++) begin
            while (i < env_rec.size() && env_rec[i]) i++;
            s = 0;
            while (i < env_rec.size() && !env_rec[i]) begin
                s++;
                i++;
            end
            w[b] = (s > 2 * UNIT);
        end
        return w;
    endfunction

    task automatic launch(input logic [7:0] a, input logic [7:0] c);
        @(negedge clk);
        address = a;
        command = c;
        start   = 1'b1;
    endtask

    // Play the expected queue cycle by cycle; optional start drop, input poke, reset
    task automatic play(input int start_off_k, input int poke_k, input bit p_start,
                        input logic [7:0] p_addr, input logic [7:0] p_cmd, input int rst_k);
        int n;
        n = exp_q.size();
        env_rec.delete();
        busy_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            env_rec.push_back(ir_envelope);
            busy_cnt += int'(busy);
            check($sformatf("cycle_%0d", k), {busy, done, ir_envelope, ir_txd}, exp_q[k-1]);
            if (k == start_off_k) start = 1'b0;
            if (k == poke_k) begin
                address = p_addr;
                command = p_cmd;
                if (p_start) start = 1'b1;
            end else if (p_start && poke_k > 0 && k == poke_k + 1) begin
                start = 1'b0;
            end
            if (k == rst_k) begin
                resetn = 1'b0;
                #1;
                check("async_reset", {busy, done, ir_envelope, ir_txd}, 4'b0000);
                @(negedge clk);
                check("reset_hold", {busy, done, ir_envelope, ir_txd}, 4'b0000);
                resetn = 1'b1;
                break;
            end
        end
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rc;

        resetn  = 1'b0;
        start   = 1'b0;
        address = '0;
        command = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, ir_envelope, ir_txd}, 4'b0000);
        resetn = 1'b1;
        push_idle(2);
        play(0, 0, 1'b0, 8'h00, 8'h00, 0);

        // Table: data, mid-frame start poke, expected payload word
        vecs[0] = '{8'h00, 8'h45, 500, 32'hBA45_FF00};
        vecs[1] = '{8'hA5, 8'h3C, 0,   32'hC33C_5AA5};
        vecs[2] = '{8'hFF, 8'h00, 0,   32'hFF00_00FF};
        vecs[3] = '{8'h12, 8'h81, 0,   32'h7E81_ED12};
        for (int v = 0; v < 4; v++) begin
            push_frame(vecs[v].addr, vecs[v].cmd);
            push_idle(2);
            launch(vecs[v].addr, vecs[v].cmd);
            play(1, vecs[v].poke_k, 1'b1, vecs[v].addr, 8'h12, 0);
            check($sformatf("busy_len_%0d", v), busy_cnt, 1210);
            check($sformatf("decode_%0d", v), decode(), vecs[v].exp_word);
        end

        // Reset in the middle of a frame, then idle, then a clean frame
        push_frame(8'hC3, 8'h5A);
        launch(8'hC3, 8'h5A);
        play(1, 0, 1'b0, 8'h00, 8'h00, 700);
        push_idle(3);
        play(0, 0, 1'b0, 8'h00, 8'h00, 0);

        // Random frames against the model
        for (int r = 0; r < 4; r++) begin
            ra = 8'($urandom);
            rc = 8'($urandom);
            push_frame(ra, rc);
            push_idle(2);
            launch(ra, rc);
            play(1, 0, 1'b0, 8'h00, 8'h00, 0);
            check($sformatf("rand_decode_%0d", r), decode(), {~rc, rc, ~ra, ra});
        end

        // Reset and start together: reset wins
        @(negedge clk);
        resetn  = 1'b0;
        start   = 1'b1;
        address = 8'h33;
        command = 8'h44;
        @(negedge clk);
        check("rst_vs_start", {busy, done, ir_envelope, ir_txd}, 4'b0000);
        resetn = 1'b1;
        start  = 1'b0;
        push_idle(3);
        play(0, 0, 1'b0, 8'h00, 8'h00, 0);

`ifdef NEC_TX_REPEAT_EN
        // Held start: full frame, then repeat codes every REP units; drop start
        push_frame(8'h5C, 8'h21);
        push_busy_low(REP * UNIT - 1211);
        push_repeat();
        push_busy_low(REP * UNIT - 211);
        push_repeat();
        push_idle(5);
        launch(8'h5C, 8'h21);
        play(3900, 0, 1'b0, 8'h00, 8'h00, 0);
`else
        // Held start: back-to-back full frames, one idle (done) cycle between
        push_frame(8'h5C, 8'h21);
        push_frame(8'h9E, 8'h07);
        push_idle(3);
        launch(8'h5C, 8'h21);
        play(1212, 5, 1'b0, 8'h9E, 8'h07, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
